// File: rtl/mux8_tdm_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mux8_tdm_tx
//  Purpose  : 8-channel time-division multiplexer transmitter. A load in
//             IDLE captures the 8-bit word D; the word is then sent one bit
//             per enabled cycle on Y, with S naming the channel (slot) so a
//             far-end 1-to-8 demux can steer the bit. frame marks slot 0 and
//             done pulses once when the frame completes.
//  Option   : `define MUX8_TDM_PARITY_EN appends one even-parity cycle
//             (Y = ^Dreg, S = 7, frame = 0) after slot 7.
//  Ports    : clk   - rising-edge clock
//             rst   - synchronous active-high reset
//             En    - global enable; low freezes the block
//             load  - capture D and start a frame (only while ready)
//             D     - parallel channel data, D[k] sent in slot k
//             ready - idle and able to accept a load
//             Y     - serial data bit
//             S     - current slot / channel index
//             valid - Y and S are meaningful this cycle
//             frame - high in slot 0 only
//             done  - one-cycle pulse when a frame completes
//  Revision : 1.0 - initial release
// ============================================================================
module mux8_tdm_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       En,
  input  logic       load,
  input  logic [7:0] D,
  output logic       ready,
  output logic       Y,
  output logic [2:0] S,
  output logic       valid,
  output logic       frame,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1
`ifdef MUX8_TDM_PARITY_EN
    ,
    PAR  = 2'd2
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] dreg_q, dreg_d;
  logic [2:0] s_q, s_d;
  logic       y_q, y_d;
  logic       valid_q, valid_d;
  logic       frame_q, frame_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  // State and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dreg_q  <= 8'd0;
      s_q     <= 3'd0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dreg_q  <= dreg_d;
      s_q     <= s_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Next-state / next-output logic. The defaults are the frozen (En=0)
  // behaviour: state, slot, data and ready hold while the strobes drop.
  always_comb begin
    state_d = state_q;
    dreg_d  = dreg_q;
    s_d     = s_q;
    ready_d = ready_q;
    y_d     = 1'b0;
    valid_d = 1'b0;
    frame_d = 1'b0;
    done_d  = 1'b0;

    if (En) begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_d = SLOT;
            dreg_d  = D;
            s_d     = 3'd0;
            y_d     = D[0];
            valid_d = 1'b1;
            frame_d = 1'b1;
            ready_d = 1'b0;
          end
        end

        SLOT: begin
          if (s_q == 3'd7) begin
`ifdef MUX8_TDM_PARITY_EN
            // Slot 7 stays on S during the parity cycle.
            state_d = PAR;
            y_d     = ^dreg_q;
            valid_d = 1'b1;
`else
            state_d = IDLE;
            s_d     = 3'd0;
            ready_d = 1'b1;
            done_d  = 1'b1;
`endif
          end else begin
            // Slot index saturates at 7; slot 0 is only entered from IDLE.
            s_d     = s_q + 3'd1;
            y_d     = dreg_q[s_d];
            valid_d = 1'b1;
          end
        end

`ifdef MUX8_TDM_PARITY_EN
        PAR: begin
          state_d = IDLE;
          s_d     = 3'd0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
`endif

        default: begin
          state_d = IDLE;
          s_d     = 3'd0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign Y     = y_q;
  assign S     = s_q;
  assign valid = valid_q;
  assign frame = frame_q;
  assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mux8_tdm_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux8_tdm_tx
//  Purpose  : Self-checking bench for mux8_tdm_tx. A frame-level model
//             predicts the ordered stream of output beats and done pulses
//             into a queue; a negedge monitor pops and compares them, and
//             also checks ready timing and the quiet/hold behaviour of the
//             outputs between beats.
//  Option   : honours `define MUX8_TDM_PARITY_EN (adds the parity beat).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux8_tdm_tx;

`ifdef MUX8_TDM_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       En;
  logic       load;
  logic [7:0] D;
  logic       ready;
  logic       Y;
  logic [2:0] S;
  logic       valid;
  logic       frame;
  logic       done;

  mux8_tdm_tx dut (
    .clk   (clk),
    .rst   (rst),
    .En    (En),
    .load  (load),
    .D     (D),
    .ready (ready),
    .Y     (Y),
    .S     (S),
    .valid (valid),
    .frame (frame),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_done;
    logic [2:0] s;
    logic       y;
    logic       fr;
  } exp_t;

  exp_t q[$];
  int   busy    = 0;     // enabled edges left until the frame's done edge
  int   vectors = 0;
  int   miscmp  = 0;
  bit   mon_en  = 1'b0;
  logic [2:0] last_s = 3'd0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference model: an accepted load yields the 8 data beats
  // (plus parity) and a done token; reset discards whatever is outstanding.
  always @(posedge clk) begin
    if (rst) begin
      busy = 0;
      q.delete();
    end else if (En) begin
      if (busy == 0) begin
        if (load) begin
          busy = FRAME_LEN;
          for (int k = 0; k < 8; k++)
            q.push_back('{1'b0, 3'(k), D[k], (k == 0)});
`ifdef MUX8_TDM_PARITY_EN
          q.push_back('{1'b0, 3'd7, ^D, 1'b0});
`endif
          q.push_back('{1'b1, 3'd0, 1'b0, 1'b0});
        end
      end else begin
        busy = busy - 1;
      end
    end
  end

  // Monitor: samples away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (valid && done) begin
        vectors++;
        miscmp++;
        $display("FAIL valid_done_overlap: valid and done both high at %0t", $time);
      end
      if (valid) begin
        if (q.size() == 0) begin
          vectors++;
          miscmp++;
          $display("FAIL beat_unexpected: got S=%0d Y=%0b frame=%0b, expected none at %0t",
                   S, Y, frame, $time);
        end else begin
          e = q.pop_front();
          chk("beat{done,S,Y,frame}", {10'd0, 1'b0, S, Y, frame},
              {10'd0, e.is_done, e.s, e.y, e.fr});
          last_s = S;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          vectors++;
          miscmp++;
          $display("FAIL done_unexpected: got done=1, expected 0 at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("done_token", {15'd0, e.is_done}, 16'd1);
        end
      end
      chk("ready", {15'd0, ready}, {15'd0, (busy == 0)});
      if (!valid) begin
        chk("quiet{Y,frame}", {14'd0, Y, frame}, 16'd0);
        if (busy == 0) chk("idle_S", {13'd0, S}, 16'd0);
        else           chk("hold_S", {13'd0, S}, {13'd0, last_s});
      end
    end
  end

  task automatic cyc(input logic en, input logic ld, input logic [7:0] d, input logic r);
    En   = en;
    load = ld;
    D    = d;
    rst  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    En   = 1'b0;
    load = 1'b0;
    D    = 8'h00;
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);   // reset beats En and load
    mon_en = 1'b1;

    // Known vector, load on the first edge after reset.
    cyc(1'b1, 1'b1, 8'b1010_0110, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);

    // Back-to-back frames with load held high.
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);

    // Freeze for 3 cycles with slot 3 on the outputs.
    cyc(1'b1, 1'b1, 8'h5C, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);

    // Reset with slot 5 on the outputs; D churns throughout.
    cyc(1'b1, 1'b1, 8'h3B, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    cyc(1'b1, 1'b0, 8'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);

    // Parity vector (plain frame when parity is not built in).
    cyc(1'b1, 1'b1, 8'b0000_0111, 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);

    // Load with En low while idle is ignored.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 8) != 0, ($urandom % 3) == 0, 8'($urandom),
          ($urandom % 100) == 0);

    // Drain, bounded.
    for (int i = 0; i < 40 && busy != 0; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("drain_busy", 16'(busy), 16'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    chk("drain_queue", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
`default_nettype wire
